// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-input registered selector with per-channel valid/ready and a
// round-robin (or fixed lowest-index) arbiter feeding one output register.
//
// Handshake rules, identical on every channel and on the output side:
//   a transfer happens on a rising clk edge where valid and ready are both 1;
//   ready may depend on valid but never on data; a producer may hold or drop
//   valid while ready is low without side effects.
// The output register reloads whenever it is empty or being drained
// (load_en = !out_valid || out_ready), so a new payload can be captured on the
// same edge that the old one leaves, giving one transfer per cycle.
module rr_arb_mux #(
  parameter int  NUM_INPUTS  = 4,
  parameter int  DATA_WIDTH  = 32,
  parameter int  ROUND_ROBIN = 1,
  localparam int SEL_WIDTH   = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [SEL_WIDTH-1:0]             out_sel,
  input  logic                             out_ready
);

  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_INPUTS - 1);

  // Registered state
  logic [SEL_WIDTH-1:0]  ptr_q,       ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_WIDTH-1:0]  out_sel_q,   out_sel_d;

  // Arbitration results
  logic                  load_en;
  logic                  grant_found;
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  xfer;
  int                    scan_base;
  int                    scan_cand;

  // Output register may accept a new payload when empty or being drained
  always_comb begin
    load_en = !out_valid_q || out_ready;
  end

  // Scan channels from the priority base upward with wrap; first valid wins
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    scan_cand   = 0;
    scan_base   = (ROUND_ROBIN != 0) ? int'(ptr_q) : 0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      scan_cand = scan_base + k;
      if (scan_cand >= NUM_INPUTS) begin
        scan_cand = scan_cand - NUM_INPUTS;
      end
      if (!grant_found && in_valid[scan_cand]) begin
        grant_found = 1'b1;
        grant_idx   = SEL_WIDTH'(scan_cand);
        grant_data  = in_data[scan_cand*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // One-hot ready to the winner only when the output can load; silent in reset
  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && grant_found) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // A transfer occurs exactly when the winner is offered ready
  always_comb begin
    xfer = load_en && grant_found;
  end

  // Next-state for output register and rotating priority pointer
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      // Empty or drained with nothing new: output goes idle, payload held
      out_valid_d = grant_found;
    end
    if (xfer) begin
      out_data_d = grant_data;
      out_sel_d  = grant_idx;
      // Pointer moves just past the winner so it has lowest priority next
      if (grant_idx == LAST_IDX) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + SEL_WIDTH'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
